mem_port_arbiter: RTL and testbench

// Shares one single-port unified memory between the pipeline's instruction-fetch (IF) port and data (MEM-stage) port.

---
 rtl/mem_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shared single-port memory arbiter for the IF and MEM-stage ports.
// Data port wins ties; a starvation counter forces fetch progress.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              pipe_stall
);

  localparam int CW = 4;
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic              own_d;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  state_t            state_q;
  state_t            state_d;
  cmd_t              cmd_q;
  cmd_t              cmd_d;
  logic [CW-1:0]     cnt_q;
  logic [SW-1:0]     starve_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              take;
  logic              gnt_d;
  logic              starved;
  logic              last_wait;

  assign starved   = (starve_q == SW'(STARVE_MAX));
  assign last_wait = (state_q == WAIT) && (cnt_q == CW'(1));

  // Pick a winner; data wins ties unless fetch is starved.
  always_comb begin
    gnt_d = 1'b0;
    unique case (1'b1)
      d_req & ~if_req: gnt_d = 1'b1;
      if_req & ~d_req: gnt_d = 1'b0;
      default:         gnt_d = ~starved;
    endcase
  end

  // Command captured at grant; fetches never write.
  always_comb begin
    cmd_d       = cmd_q;
    cmd_d.own_d = gnt_d;
    cmd_d.we    = gnt_d & d_we;
    cmd_d.addr  = gnt_d ? d_addr : if_addr;
    cmd_d.wdata = gnt_d ? d_wdata : cmd_q.wdata;
  end

  // Next-state logic for the transaction sequencer.
  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_req | d_req) begin
          take    = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (cnt_q == CW'(1)) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Registered command held for the whole transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      cmd_q <= '0;
    else if (take) cmd_q <= cmd_d;
  end

  // Starvation counter: counts data wins over a waiting fetch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
    end else if (take) begin
      if (!gnt_d)              starve_q <= '0;
      else if (if_req && !starved) starve_q <= starve_q + SW'(1);
    end
  end

  // Latency counter loaded at issue, counts down through WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    cnt_q <= '0;
    else if (state_q == ISSUE)   cnt_q <= CW'(MEM_LAT);
    else if (state_q == WAIT)    cnt_q <= cnt_q - CW'(1);
  end

  // Read data lands in the owner's register in the last WAIT cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else if (last_wait && !cmd_q.we) begin
      if (cmd_q.own_d) d_rdata_q  <= mem_rdata;
      else             if_rdata_q <= mem_rdata;
    end
  end

  assign mem_en    = (state_q == ISSUE);
  assign mem_we    = cmd_q.we;
  assign mem_addr  = cmd_q.addr;
  assign mem_wdata = cmd_q.wdata;

  assign if_ready  = (state_q == RESP) & ~cmd_q.own_d;
  assign d_ready   = (state_q == RESP) &  cmd_q.own_d;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

  assign pipe_stall = (if_req & ~if_ready) | (d_req & ~d_ready);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter.
// Memory model returns data only in the exact valid cycle.
module tb_mem_port_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        pipe_stall;

  int nvec = 0;
  int nerr = 0;

  bit [LAT-1:0] vpipe = '0;
  logic [31:0]  apipe [LAT];

  mem_port_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .MEM_LAT(LAT),
    .STARVE_MAX(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .if_req(if_req),
    .if_addr(if_addr),
    .if_ready(if_ready),
    .if_rdata(if_rdata),
    .d_req(d_req),
    .d_we(d_we),
    .d_addr(d_addr),
    .d_wdata(d_wdata),
    .d_ready(d_ready),
    .d_rdata(d_rdata),
    .mem_en(mem_en),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .pipe_stall(pipe_stall)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a == 32'h10) ? 32'h0050_0093 : {a[15:0], ~a[15:0]};
  endfunction

  always @(posedge clk) begin
    vpipe[0] <= mem_en & ~mem_we;
    apipe[0] <= mem_addr;
    for (int i = 1; i < LAT; i++) begin
      vpipe[i] <= vpipe[i-1];
      apipe[i] <= apipe[i-1];
    end
  end

  assign mem_rdata = vpipe[LAT-1] ? mem_val(apipe[LAT-1]) : 32'hBAD0_BAD0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    cyc();
    cyc();
    chk("rst_en", mem_en, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_ifr", if_ready, 0);
    chk("rst_dr", d_ready, 0);
    chk("rst_ifd", if_rdata, 0);
    chk("rst_stall", pipe_stall, 0);
    rst = 1'b1;
    cyc();
    cyc();

    // 1: fetch only
    if_req = 1'b1;
    if_addr = 32'h10;
    #1;
    chk("t1_stall_c0", pipe_stall, 1);
    chk("t1_en_c0", mem_en, 0);
    cyc();
    chk("t1_en_c1", mem_en, 1);
    chk("t1_addr_c1", mem_addr, 32'h10);
    chk("t1_we_c1", mem_we, 0);
    cyc();
    chk("t1_en_c2", mem_en, 0);
    chk("t1_stall_c2", pipe_stall, 1);
    cyc();
    chk("t1_rdy_c3", if_ready, 0);
    cyc();
    chk("t1_rdy_c4", if_ready, 1);
    chk("t1_data", if_rdata, 32'h0050_0093);
    chk("t1_stall_c4", pipe_stall, 0);
    chk("t1_drdy_c4", d_ready, 0);
    if_req = 1'b0;
    cyc();
    chk("t1_rdy_c5", if_ready, 0);
    cyc();

    // 2: both request, data wins
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 32'h40;
    if_req = 1'b1;
    if_addr = 32'h14;
    cyc();
    chk("t2_en_c1", mem_en, 1);
    chk("t2_addr_c1", mem_addr, 32'h40);
    cyc();
    cyc();
    cyc();
    chk("t2_drdy_c4", d_ready, 1);
    chk("t2_ifr_c4", if_ready, 0);
    chk("t2_ddata", d_rdata, mem_val(32'h40));
    chk("t2_stall_c4", pipe_stall, 1);
    d_req = 1'b0;
    cyc();
    cyc();
    chk("t2_en_c6", mem_en, 1);
    chk("t2_addr_c6", mem_addr, 32'h14);
    cyc();
    cyc();
    chk("t2_ifr_c8", if_ready, 0);
    cyc();
    chk("t2_ifr_c9", if_ready, 1);
    chk("t2_ifdata", if_rdata, mem_val(32'h14));
    if_req = 1'b0;
    cyc();
    cyc();

    // 3: starvation, four data grants then fetch
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 32'h80;
    if_req = 1'b1;
    if_addr = 32'h20;
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk($sformatf("t3_en_%0d", k), mem_en, 1);
      chk($sformatf("t3_addr_%0d", k), mem_addr,
          (k == 4) ? 32'h20 : 32'h80);
      cyc();
      cyc();
      cyc();
      chk($sformatf("t3_rdy_%0d", k), {if_ready, d_ready},
          (k == 4) ? 2'b10 : 2'b01);
      if (k == 4) begin
        chk("t3_ifdata", if_rdata, mem_val(32'h20));
        if_req = 1'b0;
      end
      if (k == 5) d_req = 1'b0;
      cyc();
    end
    cyc();

    // 4: store
    d_req = 1'b1;
    d_we = 1'b1;
    d_addr = 32'h8;
    d_wdata = 32'hDEAD_BEEF;
    cyc();
    chk("t4_en_c1", mem_en, 1);
    chk("t4_we_c1", mem_we, 1);
    chk("t4_addr_c1", mem_addr, 32'h8);
    chk("t4_wd_c1", mem_wdata, 32'hDEAD_BEEF);
    cyc();
    chk("t4_en_c2", mem_en, 0);
    cyc();
    cyc();
    chk("t4_drdy_c4", d_ready, 1);
    chk("t4_dkeep", d_rdata, mem_val(32'h80));
    d_req = 1'b0;
    d_we = 1'b0;
    cyc();
    chk("t4_drdy_c5", d_ready, 0);
    chk("t4_wehold", mem_we, 1);
    cyc();

    // 5: reset during WAIT
    if_req = 1'b1;
    if_addr = 32'h30;
    cyc();
    chk("t5_en_c1", mem_en, 1);
    cyc();
    rst = 1'b0;
    #1;
    chk("t5_rst_addr", mem_addr, 0);
    chk("t5_rst_ifd", if_rdata, 0);
    chk("t5_rst_dd", d_rdata, 0);
    chk("t5_rst_stall", pipe_stall, 1);
    cyc();
    chk("t5_rst_rdy3", if_ready, 0);
    chk("t5_rst_en3", mem_en, 0);
    cyc();
    chk("t5_rst_rdy4", if_ready, 0);
    rst = 1'b1;
    cyc();
    chk("t5_en_r1", mem_en, 1);
    chk("t5_addr_r1", mem_addr, 32'h30);
    cyc();
    cyc();
    chk("t5_rdy_r3", if_ready, 0);
    cyc();
    chk("t5_rdy_r4", if_ready, 1);
    chk("t5_ifdata", if_rdata, mem_val(32'h30));
    if_req = 1'b0;
    cyc();
    chk("t5_idle_stall", pipe_stall, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
